// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, sizing constants, initial hash values.
package sha256_pkg;

  localparam int SHA_ROUNDS    = 64;
  localparam int SHA_MSG_WORDS = 16;
  localparam int SHA_IDX_W     = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_ADD   = 3'd3,
    S_OUT   = 3'd4
  } sha_state_e;

  localparam logic [31:0] SHA_H0 = 32'h6a09e667;
  localparam logic [31:0] SHA_H1 = 32'hbb67ae85;
  localparam logic [31:0] SHA_H2 = 32'h3c6ef372;
  localparam logic [31:0] SHA_H3 = 32'ha54ff53a;
  localparam logic [31:0] SHA_H4 = 32'h510e527f;
  localparam logic [31:0] SHA_H5 = 32'h9b05688c;
  localparam logic [31:0] SHA_H6 = 32'h1f83d9ab;
  localparam logic [31:0] SHA_H7 = 32'h5be0cd19;

  // Initial value H[idx] for the round engine's working-register load.
  function automatic logic [31:0] sha_h_init(input logic [2:0] idx);
    case (idx)
      3'd0:    return SHA_H0;
      3'd1:    return SHA_H1;
      3'd2:    return SHA_H2;
      3'd3:    return SHA_H3;
      3'd4:    return SHA_H4;
      3'd5:    return SHA_H5;
      3'd6:    return SHA_H6;
      default: return SHA_H7;
    endcase
  endfunction

endpackage

// File: rtl/sha256_idx_counter.sv
// Loadable up-counter with clear and enable; holds at MAX and flags it with tc.
module sha256_idx_counter
  import sha256_pkg::*;
#(
  parameter int W   = SHA_IDX_W,
  parameter int MAX = SHA_ROUNDS - 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(MAX));

  // Saturating at MAX keeps the index from wrapping while the FSM leaves RUN.
  always_ff @(posedge clock) begin
    if (reset)                count <= '0;
    else if (clear)           count <= '0;
    else if (load)            count <= load_val;
    else if (enable && !tc)   count <= count + 1'b1;
  end

endmodule

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 per-block sequencer: block intake, schedule/round drive, digest handoff.
// Optional SHA256_CTRL_PERF_EN adds saturating busy-cycle and accepted-block counters.
module sha256_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA_ROUNDS,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             block_valid,
  input  logic             block_last,
  output logic             block_ready,
  output logic             sched_enable,
  output logic [IDX_W-1:0] sched_index,
  output logic             sched_index_complete,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic             hash_init,
  output logic             digest_add,
  output logic             digest_valid,
  input  logic             digest_ready
`ifdef SHA256_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_blocks
`endif
);

  sha_state_e state;
  logic       first_q;
  logic       last_q;
  logic       accept;
  logic       idx_tc;

  assign accept               = (state == S_IDLE) && block_valid;
  assign hash_init            = accept && first_q;
  assign sched_index_complete = sched_enable && idx_tc;

  sha256_idx_counter #(
    .W   (IDX_W),
    .MAX (ROUNDS - 1)
  ) u_idx (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept),
    .load     (1'b0),
    .load_val ('0),
    .enable   (state == S_RUN),
    .count    (sched_index),
    .tc       (idx_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      first_q      <= 1'b1;
      last_q       <= 1'b0;
      block_ready  <= 1'b1;
      sched_enable <= 1'b0;
      digest_add   <= 1'b0;
      digest_valid <= 1'b0;
      round_en     <= 1'b0;
      round_idx    <= '0;
    end else begin
      // Round strobe trails the schedule request by the schedule unit's cur_w register.
      round_en   <= sched_enable;
      round_idx  <= sched_index;
      digest_add <= 1'b0;
      case (state)
        S_IDLE: if (block_valid) begin
          state        <= S_RUN;
          last_q       <= block_last;
          first_q      <= 1'b0;
          block_ready  <= 1'b0;
          sched_enable <= 1'b1;
        end
        S_RUN: if (idx_tc) begin
          state        <= S_FLUSH;
          sched_enable <= 1'b0;
        end
        S_FLUSH: begin
          state      <= S_ADD;
          digest_add <= 1'b1;
        end
        S_ADD: begin
          if (last_q) begin
            state        <= S_OUT;
            first_q      <= 1'b1;
            digest_valid <= 1'b1;
          end else begin
            state       <= S_IDLE;
            block_ready <= 1'b1;
          end
        end
        S_OUT: if (digest_ready) begin
          state        <= S_IDLE;
          digest_valid <= 1'b0;
          block_ready  <= 1'b1;
        end
        default: begin
          state        <= S_IDLE;
          block_ready  <= 1'b1;
          sched_enable <= 1'b0;
          digest_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHA256_CTRL_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_blocks <= '0;
    end else begin
      if (state != S_IDLE && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (accept && perf_blocks != '1)          perf_blocks <= perf_blocks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Randomised + directed bench for sha256_sched_ctrl against a timeline reference model.
module tb_sha256_sched_ctrl;

  localparam int IW = 6;

  logic          clock = 1'b0;
  logic          reset, block_valid, block_last, digest_ready;
  logic          block_ready, sched_enable, sched_index_complete, round_en;
  logic          hash_init, digest_add, digest_valid;
  logic [IW-1:0] sched_index, round_idx;
`ifdef SHA256_CTRL_PERF_EN
  logic [31:0]   perf_cycles, perf_blocks;
`endif

  always #5 clock = ~clock;

  sha256_sched_ctrl dut (
    .clock                (clock),
    .reset                (reset),
    .block_valid          (block_valid),
    .block_last           (block_last),
    .block_ready          (block_ready),
    .sched_enable         (sched_enable),
    .sched_index          (sched_index),
    .sched_index_complete (sched_index_complete),
    .round_en             (round_en),
    .round_idx            (round_idx),
    .hash_init            (hash_init),
    .digest_add           (digest_add),
    .digest_valid         (digest_valid),
    .digest_ready         (digest_ready)
`ifdef SHA256_CTRL_PERF_EN
    ,
    .perf_cycles          (perf_cycles),
    .perf_blocks          (perf_blocks)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: mode 0 idle, 1 busy (m_d = cycles since accept), 2 holding digest.
  int          m_mode = 0;
  int          m_d    = 0;
  bit          m_first, m_last;
  int unsigned m_pc, m_pb;
  bit          chk_on = 0;
  int          cyc    = 0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_mode = 0; m_d = 0; m_first = 1; m_last = 0; m_pc = 0; m_pb = 0; chk_on = 1;
    end else begin
      if (m_mode != 0) m_pc++;
      case (m_mode)
        0: if (block_valid) begin
          m_mode = 1; m_d = 1; m_last = block_last; m_first = 0; m_pb++;
        end
        1: begin
          m_d++;
          if (m_d == 67) begin
            if (m_last) begin m_mode = 2; m_first = 1; end
            else m_mode = 0;
          end
        end
        2: if (digest_ready) m_mode = 0;
        default: ;
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      bit en_e, ren_e;
      en_e  = (m_mode == 1) && (m_d <= 64);
      ren_e = (m_mode == 1) && (m_d >= 2) && (m_d <= 65);
      chk("block_ready",  block_ready,  m_mode == 0);
      chk("hash_init",    hash_init,    (m_mode == 0) && block_valid && m_first);
      chk("sched_enable", sched_enable, en_e);
      chk("idx_complete", sched_index_complete, (m_mode == 1) && (m_d == 64));
      chk("round_en",     round_en,     ren_e);
      chk("digest_add",   digest_add,   (m_mode == 1) && (m_d == 66));
      chk("digest_valid", digest_valid, m_mode == 2);
      if (en_e)  chk("sched_index", sched_index, 32'(m_d - 1));
      if (ren_e) chk("round_idx",   round_idx,   32'(m_d - 2));
`ifdef SHA256_CTRL_PERF_EN
      chk("perf_cycles", perf_cycles, m_pc);
      chk("perf_blocks", perf_blocks, m_pb);
`endif
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_dv();
    int n = 0;
    while (!digest_valid && n < 300) begin tick(); n++; end
    if (!digest_valid) chk("dv_timeout", 0, 1);
  endtask

  initial begin
    int t_acc, n;
    reset = 1; block_valid = 0; block_last = 0; digest_ready = 0;
    repeat (3) tick();
    reset = 0;
    chk("rst_sched_index", sched_index, 0);
    chk("rst_round_idx",   round_idx,   0);

    // single-block message
    block_valid = 1; block_last = 1; digest_ready = 1; #1;
    chk("hash_init_first", hash_init, 1);
    t_acc = cyc; tick(); block_valid = 0;
    wait_dv();
    chk("lat_single", cyc - t_acc, 67);
    tick();
`ifdef SHA256_CTRL_PERF_EN
    chk("perf_cycles_single", perf_cycles, 67);
    chk("perf_blocks_single", perf_blocks, 1);
`endif

    // two-block message; valid held through RUN must be ignored
    block_valid = 1; block_last = 0; t_acc = cyc; tick();
    block_last = 1; n = 0;
    while (!block_ready && n < 200) begin tick(); n++; end
    chk("accept2_at", cyc - t_acc, 67);
    #1 chk("hash_init_second", hash_init, 0);
    tick(); block_valid = 0;
    wait_dv();
    chk("lat_two_block", cyc - t_acc, 134);
    tick();

    // digest backpressure, then ready together with a new block on the exit cycle
    digest_ready = 0; block_valid = 1; block_last = 1; tick(); block_valid = 0;
    wait_dv();
    repeat (10) begin
      chk("bp_valid", digest_valid, 1);
      chk("bp_ready", block_ready, 0);
      tick();
    end
    digest_ready = 1; block_valid = 1; tick();
    digest_ready = 0;
    chk("bp_release_ready", block_ready, 1);
    tick(); block_valid = 0; digest_ready = 1;
    chk("accept_after_out", sched_enable, 1);

    // reset mid-block at sched_index 30
    repeat (30) tick();
    chk("pre_reset_index", sched_index, 30);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_ready", block_ready, 1);
    chk("mid_rst_enable", sched_enable, 0);
    chk("mid_rst_index", sched_index, 0);
    chk("mid_rst_round_en", round_en, 0);
    repeat (80) begin
      chk("mid_rst_no_add", digest_add, 0);
      tick();
    end
    block_valid = 1; block_last = 1; #1;
    chk("hash_init_after_rst", hash_init, 1);
    tick(); block_valid = 0;
    wait_dv(); tick();

    // random traffic
    repeat (3000) begin
      block_valid  = 1'($urandom_range(0, 1));
      block_last   = 1'($urandom_range(0, 1));
      digest_ready = ($urandom_range(0, 3) == 0);
      reset        = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 0; block_valid = 0; tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
